// File: rtl/trace_capture_buf_pkg.sv
// trace_capture_buf_pkg: state encoding, entry layout and packing shared by the trace recorder.
package trace_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;
  localparam int INSTR_W = 32;
  localparam int RD_W = 5;
  localparam int WEN_W = 1;
  localparam int XLEN_MAX = 64;
  localparam int EMAX_W = 2 * XLEN_MAX + INSTR_W + RD_W + WEN_W;
  typedef logic [EMAX_W-1:0] emax_t;
  function automatic int entry_w(input int xlen);
    return 2 * xlen + INSTR_W + RD_W + WEN_W;
  endfunction
  // Fields are packed LSB-up at the caller's xlen, so pc ends up in the MSBs of entry_w(xlen).
  function automatic emax_t pack_entry(input int xlen, input logic [XLEN_MAX-1:0] pc,
                                       input logic [INSTR_W-1:0] instr, input logic [RD_W-1:0] rd,
                                       input logic wen, input logic [XLEN_MAX-1:0] wb);
    return (emax_t'(pc) << (xlen + INSTR_W + RD_W + WEN_W)) |
           (emax_t'(instr) << (xlen + RD_W + WEN_W)) |
           (emax_t'(rd) << (xlen + WEN_W)) |
           (emax_t'(wen) << xlen) |
           emax_t'(wb);
  endfunction
endpackage

// File: rtl/trace_capture_buf_if.sv
// trace_capture_buf_if: retire-tap, control and readout signals of the trace recorder.
interface trace_capture_buf_if import trace_pkg::*; #(parameter int XLEN = 32, parameter int DEPTH = 16);
  localparam int AW = $clog2(DEPTH);
  logic cap_valid;
  logic [XLEN-1:0] cap_pc;
  logic [31:0] cap_instr;
  logic [4:0] cap_rd;
  logic cap_wen;
  logic [XLEN-1:0] cap_wb;
  logic arm;
  logic [XLEN-1:0] trig_pc;
  logic rd_req;
  logic [AW-1:0] rd_idx;
  logic rd_valid;
  logic [2*XLEN+INSTR_W+RD_W+WEN_W-1:0] rd_data;
  logic [1:0] state;
  logic [AW:0] count;
  logic wrapped;
  modport master (output cap_valid, cap_pc, cap_instr, cap_rd, cap_wen, cap_wb, arm, trig_pc, rd_req, rd_idx,
                  input rd_valid, rd_data, state, count, wrapped);
  modport slave (input cap_valid, cap_pc, cap_instr, cap_rd, cap_wen, cap_wb, arm, trig_pc, rd_req, rd_idx,
                 output rd_valid, rd_data, state, count, wrapped);
endinterface

// File: rtl/trace_capture_buf_ram.sv
// trace_ram: DEPTH x W storage, one write port and one registered read port, no reset.
module trace_ram #(parameter int W = 102, parameter int DEPTH = 16, localparam int AW = $clog2(DEPTH)) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  q
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/trace_capture_buf.sv
// trace_capture_buf: circular retire-trace recorder with in-order readout; TRACE_TRIG_EN enables PC trigger + post-capture.
module trace_capture_buf import trace_pkg::*; #(
  parameter int XLEN = 32,
  parameter int DEPTH = 16,
  parameter int POST_TRIG = DEPTH / 2
) (
  input logic clk,
  input logic rst,
  trace_capture_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int ENTRY_W = entry_w(XLEN);
  state_t st, st_n;
  logic [AW-1:0] wptr, wptr_n, raddr;
  logic [AW:0] cnt, cnt_n;
  logic wrapped, wrapped_n, we, rd_ok, rd_valid, zero_q;
  logic [ENTRY_W-1:0] entry, q;
`ifdef TRACE_TRIG_EN
  logic [AW-1:0] post, post_n;
`endif
  assign entry = ENTRY_W'(pack_entry(XLEN, XLEN_MAX'(bus.cap_pc), bus.cap_instr, bus.cap_rd, bus.cap_wen,
                                     XLEN_MAX'(bus.cap_wb)));
  assign rd_ok = bus.rd_req && st == DONE;
  assign raddr = (wrapped ? wptr : '0) + bus.rd_idx;
  always_comb begin
    st_n = st;
    wptr_n = wptr;
    cnt_n = cnt;
    wrapped_n = wrapped;
    we = 1'b0;
`ifdef TRACE_TRIG_EN
    post_n = post;
`endif
    if (bus.arm) begin
      st_n = RUN;
      wptr_n = '0;
      cnt_n = '0;
      wrapped_n = 1'b0;
    end else if (bus.cap_valid && (st == RUN || st == POST)) begin
      we = 1'b1;
      wptr_n = wptr + 1'b1;
      cnt_n = cnt == (AW+1)'(DEPTH) ? cnt : cnt + 1'b1;
`ifdef TRACE_TRIG_EN
      wrapped_n = wrapped | (wptr == AW'(DEPTH - 1));
      if (st == RUN && bus.cap_pc == bus.trig_pc) begin
        post_n = AW'(POST_TRIG);
        st_n = POST_TRIG == 0 ? DONE : POST;
      end else if (st == POST) begin
        post_n = post - 1'b1;
        st_n = post == AW'(1) ? DONE : POST;
      end
`else
      st_n = cnt == (AW+1)'(DEPTH - 1) ? DONE : RUN;
`endif
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      wptr <= '0;
      cnt <= '0;
      wrapped <= 1'b0;
      rd_valid <= 1'b0;
      zero_q <= 1'b1;
`ifdef TRACE_TRIG_EN
      post <= '0;
`endif
    end else begin
      st <= st_n;
      wptr <= wptr_n;
      cnt <= cnt_n;
      wrapped <= wrapped_n;
      rd_valid <= rd_ok;
      if (rd_ok) zero_q <= {1'b0, bus.rd_idx} >= cnt;
`ifdef TRACE_TRIG_EN
      post <= post_n;
`endif
    end
  end
  trace_ram #(.W(ENTRY_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .we(we), .waddr(wptr), .wdata(entry), .re(rd_ok), .raddr(raddr), .q(q)
  );
  // zero_q resets high so rd_data reads 0 out of reset despite the unreset RAM.
  assign bus.rd_data = zero_q ? '0 : q;
  assign bus.rd_valid = rd_valid;
  assign bus.state = st;
  assign bus.count = cnt;
  assign bus.wrapped = wrapped;
endmodule
